uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver. Configurable data width, parity mode and stop-bit count; mid-bit majority sampling with false-start rejection. Delivers each frame through a valid/ready holding register with per-frame parity and framing error flags and an overrun pulse. Sits between the pad-side rx pin and byte consumers such as a command parser or FIFO.

Parameters:
CLOCK_RATE, 100000000, system clock in Hz
BAUD_RATE, 115200, line rate in baud
OVR, 16, oversampling ticks per bit; power of two, 8..32
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx  in  1  asynchronous serial input, idle high
m_data  out  DATA_BITS  received word, LSB first on the line
m_perr  out  1  parity error for the word in m_data
m_ferr  out  1  framing error (a stop bit sampled 0) for the word in m_data
m_valid  out  1  m_data/m_perr/m_ferr hold a frame
m_ready  in  1  consumer accepts the frame when m_valid & m_ready
overrun  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset: m_data 0, m_perr 0, m_ferr 0, m_valid 0, overrun 0. FSM goes to IDLE, tick counter 0, synchroniser is set to 1. Reset mid-frame discards the partial frame.
- rx passes through a 2-FF synchroniser. The tick counter generates one tick every DIV = CLOCK_RATE/(BAUD_RATE*OVR) clocks; DIV >= 2 is enforced by an elaboration check.
- Sampling: the bit value is the majority of synchronised rx at ticks OVR/2-1, OVR/2 and OVR/2+1 within the bit period.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: synchronised rx is 0. The bit-tick phase resets to 0 on that edge.
- START: majority 1 -> IDLE (false start, nothing reported). Majority 0 -> DATA.
- DATA: shift in DATA_BITS bits, LSB first. Exit to PARITY if PARITY != 0, else to STOP.
- PARITY: the error bit is XOR of the data bits and the parity bit, inverted for odd parity. Even parity expects the total count of ones to be even.
- STOP: STOP_BITS bits are checked; any 0 sets the framing error. The frame completes at the mid-bit decision of the last stop bit, and the FSM returns to IDLE immediately for resync.
- Completion latency: m_valid rises on the clock after the last stop-bit decision.
- Holding register load: when m_valid is 0, or m_valid & m_ready in the same cycle as completion, load data and flags and set m_valid=1. Accept and load in the same cycle gives no overrun.
- Overrun: on completion with m_valid=1 and m_ready=0, keep the old frame, drop the new one, and pulse overrun for 1 cycle.
- Handshake: m_valid stays high and m_data/flags stay stable until m_ready. m_valid falls on the cycle after acceptance unless a new frame loads.
- A line held low forever yields repeated frames of 0 with m_ferr=1, unless the optional feature is enabled.

Optional Feature:
UART_RX_BREAK_DET_EN.
- Defined: adds output `brk` (1 bit), reset 0. A frame with all data bits 0, parity bit 0 if present, and a stop bit 0 is not delivered to m_data. Instead `brk` pulses 1 cycle. The FSM then waits in an extra BREAK state until synchronised rx is 1 for one full bit time, then goes to IDLE.
- Undefined: no `brk` port; such frames are delivered as data 0 with m_ferr=1.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - FSM state encoding;
  - helper function for DIV and counter widths.
- One sub-module, uart_rx_sampler, contains the synchroniser, tick divider and 3-sample majority vote. It outputs a bit_tick strobe, the sampled value and the synchronised rx. The top holds the FSM, shift register and holding register.

Test Plan:
All tests use CLOCK_RATE=12000000, BAUD_RATE=250000, OVR=16 (DIV=3, 48 clocks/bit) unless noted.
1. 8N1, send 0xA5, m_ready=1 -> m_data=0xA5, m_perr=0, m_ferr=0; m_valid high 1 cycle, rising 458..462 clocks after the start edge.
2. PARITY=1, DATA_BITS=7, send 0x07 with parity bit 0 -> m_data=0x07, m_perr=1. The same frame with parity bit 1 -> m_perr=0.
3. Low glitch of 15 clocks on the idle line -> no m_valid and no overrun; a following 0x5A frame is received correctly.
4. m_ready=0, send 0x11 then 0x22 -> m_data holds 0x11, overrun pulses exactly once. Raise m_ready -> 0x11 accepted, then m_valid=0.
5. STOP_BITS=2, second stop bit 0, data 0x3C -> m_data=0x3C, m_ferr=1. With UART_RX_BREAK_DET_EN, send 0x00 with stop 0 -> brk pulses, m_valid stays 0; the next 0x81 is received.
6. Assert rst during data bit 4 of 0xF0 -> all outputs 0 next cycle. A subsequent 0xC3 is received with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and sizing helpers for the configurable UART receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int calc_div(input int clock_rate, input int baud_rate, input int ovr);
    return clock_rate / (baud_rate * ovr);
  endfunction

  // Bits needed to hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, oversampling tick divider and 3-sample mid-bit majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVR        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic bit_tick,
  output logic sample,
  output logic rx_sync
);

  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE, OVR);
  localparam int DW  = cnt_width(DIV);
  localparam int PW  = cnt_width(OVR);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [PW-1:0] PH_A     = PW'(OVR / 2 - 2);
  localparam logic [PW-1:0] PH_B     = PW'(OVR / 2 - 1);
  localparam logic [PW-1:0] PH_C     = PW'(OVR / 2);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx_sampler: CLOCK_RATE/(BAUD_RATE*OVR) must be at least 2");
    end
    if (OVR < 8 || OVR > 32 || (OVR & (OVR - 1)) != 0) begin : g_ovr_check
      $error("uart_rx_sampler: OVR must be a power of two in 8..32");
    end
  endgenerate

  logic          sync1;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] phase;
  logic          tick;
  logic          s_a;
  logic          s_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_sync <= sync1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Restart preloads 1 to absorb the cycle spent recognising the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (restart) begin
      div_cnt <= DW'(1);
      phase   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= phase + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // phase counts completed ticks, so ticks OVR/2-1..OVR/2+1 see phase one lower.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (tick) begin
      if (phase == PH_A) s_a <= rx_sync;
      if (phase == PH_B) s_b <= rx_sync;
    end
  end

  assign bit_tick = tick && (phase == PH_C);
  assign sample   = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with valid/ready holding register.
// Optional break detection (brk output, BREAK state) when UART_RX_BREAK_DET_EN is defined.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVR        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 brk
`endif
);

  localparam logic ODD_PAR = (PARITY == PAR_ODD);

  rx_state_t            state_q, state_d;
  logic                 restart;
  logic                 bit_tick;
  logic                 sample;
  logic                 rx_sync;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_en;
  logic                 frame_done;
  logic                 frame_ferr;
  logic                 is_break;
  logic                 deliver;

  uart_rx_sampler #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE),
    .OVR       (OVR)
  ) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .restart (restart),
    .bit_tick(bit_tick),
    .sample  (sample),
    .rx_sync (rx_sync)
  );

  assign frame_ferr = ferr_q | ~sample;

`ifdef UART_RX_BREAK_DET_EN
  localparam int BIT_CLKS = calc_div(CLOCK_RATE, BAUD_RATE, OVR) * OVR;
  localparam int BW       = cnt_width(BIT_CLKS);

  logic          par_bit_q;
  logic [BW-1:0] brk_cnt_q;

  assign is_break = (shreg_q == '0) && ((PARITY == PAR_NONE) || !par_bit_q) && frame_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit_q <= 1'b0;
      brk_cnt_q <= '0;
      brk       <= 1'b0;
    end else begin
      brk <= frame_done && is_break;
      if (par_en) par_bit_q <= sample;
      if (state_q != ST_BREAK || !rx_sync) brk_cnt_q <= '0;
      else brk_cnt_q <= brk_cnt_q + 1'b1;
    end
  end
`else
  assign is_break = 1'b0;
`endif

  assign deliver = frame_done && !is_break;

  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync) begin
          restart = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = sample ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_cnt_q == 4'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          par_en  = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          stop_en = 1'b1;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_d    = is_break ? ST_BREAK : ST_IDLE;
          end
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BREAK: begin
        if (rx_sync && brk_cnt_q == BW'(BIT_CLKS - 1)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Bit counter restarts on every state change so each field counts from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (state_d != state_q) bit_cnt_q <= '0;
      else if (bit_tick)      bit_cnt_q <= bit_cnt_q + 1'b1;
      if (restart) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (shift_en) shreg_q <= {sample, shreg_q[DATA_BITS-1:1]};
      if (par_en)   perr_q  <= (^shreg_q) ^ sample ^ ODD_PAR;
      if (stop_en)  ferr_q  <= frame_ferr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_perr  <= 1'b0;
      m_ferr  <= 1'b0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= deliver && m_valid && !m_ready;
      if (deliver && (!m_valid || m_ready)) begin
        m_data  <= shreg_q;
        m_perr  <= perr_q;
        m_ferr  <= frame_ferr;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances on separate rx lines.
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 48;
  localparam int GAP      = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
  logic [7:0] d_a, d_c;
  logic [6:0] d_b;
  logic pe_a, fe_a, v_a, ovr_a;
  logic pe_b, fe_b, v_b, ovr_b;
  logic pe_c, fe_c, v_c, ovr_c;
`ifdef UART_RX_BREAK_DET_EN
  logic brk_a, brk_b, brk_c;
  int   brk_cnt_a = 0;
`endif

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   vcnt_a = 0;
  int   ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLOCK_RATE(12000000), .BAUD_RATE(250000), .OVR(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx_a), .m_data(d_a), .m_perr(pe_a), .m_ferr(fe_a),
    .m_valid(v_a), .m_ready(rdy_a), .overrun(ovr_a)
`ifdef UART_RX_BREAK_DET_EN
    , .brk(brk_a)
`endif
  );

  uart_rx_cfg #(.CLOCK_RATE(12000000), .BAUD_RATE(250000), .OVR(16),
                .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .rx(rx_b), .m_data(d_b), .m_perr(pe_b), .m_ferr(fe_b),
    .m_valid(v_b), .m_ready(rdy_b), .overrun(ovr_b)
`ifdef UART_RX_BREAK_DET_EN
    , .brk(brk_b)
`endif
  );

  uart_rx_cfg #(.CLOCK_RATE(12000000), .BAUD_RATE(250000), .OVR(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .rx(rx_c), .m_data(d_c), .m_perr(pe_c), .m_ferr(fe_c),
    .m_valid(v_c), .m_ready(rdy_c), .overrun(ovr_c)
`ifdef UART_RX_BREAK_DET_EN
    , .brk(brk_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push(input int inst, input logic [8:0] data, input logic perr,
                      input logic ferr, input bit lat);
    exp_t e;
    e.inst = inst; e.data = data; e.perr = perr; e.ferr = ferr; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic pop_check(input int inst, input logic [8:0] data, input logic perr,
                           input logic ferr);
    exp_t e;
    int   lat;
    chk("sb_has_entry", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sb_inst", 32'(inst), 32'(e.inst));
      chk("sb_data", 32'(data), 32'(e.data));
      chk("sb_perr", 32'(perr), 32'(e.perr));
      chk("sb_ferr", 32'(ferr), 32'(e.ferr));
      if (e.lat) begin
        lat = cyc - t_start;
        n_total++;
        assert (lat >= 458 && lat <= 462) n_pass++;
        else $error("FAIL latency observed=%0d expected=458..462", lat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (v_a) vcnt_a <= vcnt_a + 1;
      if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
      if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
      if (ovr_c) ovr_cnt_c <= ovr_cnt_c + 1;
`ifdef UART_RX_BREAK_DET_EN
      if (brk_a) brk_cnt_a <= brk_cnt_a + 1;
`endif
      if (v_a && rdy_a) pop_check(0, {1'b0, d_a}, pe_a, fe_a);
      if (v_b && rdy_b) pop_check(1, {2'b00, d_b}, pe_b, fe_b);
      if (v_c && rdy_c) pop_check(2, {1'b0, d_c}, pe_c, fe_c);
    end
  end

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive_bit(input int inst, input logic v);
    set_rx(inst, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic pbit, input int nstop,
                            input logic stop_last);
    @(negedge clk);
    t_start = cyc;
    drive_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(inst, data[i]);
    if (has_par) drive_bit(inst, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(inst, (i == nstop - 1) ? stop_last : 1'b1);
    set_rx(inst, 1'b1);
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    int v0, o0;
`ifdef UART_RX_BREAK_DET_EN
    int b0;
`endif
    repeat (5) @(negedge clk);
    chk("rst_m_valid", 32'(v_a), 32'd0);
    chk("rst_m_data", 32'(d_a), 32'd0);
    chk("rst_m_perr", 32'(pe_a), 32'd0);
    chk("rst_m_ferr", 32'(fe_a), 32'd0);
    chk("rst_overrun", 32'(ovr_a), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 8N1 0xA5 with latency and single-cycle valid
    v0 = vcnt_a;
    push(0, 9'h0A5, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("t1_drained", 32'(q.size()), 32'd0);
    chk("t1_valid_cycles", 32'(vcnt_a - v0), 32'd1);
    chk("t1_no_overrun", 32'(ovr_cnt_a), 32'd0);

    // 7E1 parity error and clean parity
    push(1, 9'h007, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h007, 7, 1'b1, 1'b0, 1, 1'b1);
    push(1, 9'h007, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h007, 7, 1'b1, 1'b1, 1, 1'b1);
    chk("t2_drained", 32'(q.size()), 32'd0);

    // 15-clock glitch is a false start
    v0 = vcnt_a;
    o0 = ovr_cnt_a;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (15) @(negedge clk);
    rx_a = 1'b1;
    repeat (100) @(negedge clk);
    chk("t3_no_valid", 32'(vcnt_a - v0), 32'd0);
    chk("t3_no_overrun", 32'(ovr_cnt_a - o0), 32'd0);
    push(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("t3_drained", 32'(q.size()), 32'd0);

    // overrun with consumer stalled
    rdy_a = 1'b0;
    o0 = ovr_cnt_a;
    push(0, 9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("t4_held_data", 32'(d_a), 32'h11);
    chk("t4_held_valid", 32'(v_a), 32'd1);
    chk("t4_overrun_once", 32'(ovr_cnt_a - o0), 32'd1);
    @(posedge clk);
    #1 rdy_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid_dropped", 32'(v_a), 32'd0);
    chk("t4_drained", 32'(q.size()), 32'd0);

    // 8N2 with second stop bit low
    push(2, 9'h03C, 1'b0, 1'b1, 1'b0);
    send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2, 1'b0);
    chk("t5_drained", 32'(q.size()), 32'd0);
    chk("t5_no_overrun", 32'(ovr_cnt_c), 32'd0);

    // all-zero frame with stop bit low
`ifdef UART_RX_BREAK_DET_EN
    b0 = brk_cnt_a;
    v0 = vcnt_a;
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
    chk("t5_brk_pulse", 32'(brk_cnt_a - b0), 32'd1);
    chk("t5_brk_no_valid", 32'(vcnt_a - v0), 32'd0);
`else
    push(0, 9'h000, 1'b0, 1'b1, 1'b0);
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
    chk("t5_zero_drained", 32'(q.size()), 32'd0);
`endif
    push(0, 9'h081, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("t5_after_drained", 32'(q.size()), 32'd0);

    // reset mid-frame with a stale frame held
    rdy_a = 1'b0;
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("t6_pre_data", 32'(d_a), 32'h55);
    chk("t6_pre_valid", 32'(v_a), 32'd1);
    @(negedge clk);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
    rx_a = 1'b1;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_data", 32'(d_a), 32'd0);
    chk("t6_rst_valid", 32'(v_a), 32'd0);
    chk("t6_rst_perr", 32'(pe_a), 32'd0);
    chk("t6_rst_ferr", 32'(fe_a), 32'd0);
    chk("t6_rst_overrun", 32'(ovr_a), 32'd0);
    rst = 1'b0;
    rdy_a = 1'b1;
    repeat (100) @(negedge clk);
    push(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("t6_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
